// File: rtl/axi_pkg.sv
// Shared types for the AXI read arbiter: FSM state, AR request bundle
// and AXI encoding constants. Imported by rr_arbiter and axi_rd_arbiter.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } ArbState;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Widest address the registered AR bundle can hold.
    localparam int AXI_MAX_ADDR_W = 64;

    typedef struct packed {
        logic [AXI_MAX_ADDR_W-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
    } AxiArReqSt;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks the first set request at or after ptr.
// Ports: req (request vector), ptr (search start), gnt (one-hot), idx, any.
module rr_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               any
);

    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between NUM_REQ requesters, one burst at a
// time. Ports: req_* (request in, one-hot req_ready), rsp_* (beats routed to
// the owner), ar_* / r_* (AXI AR and R channels). Build option
// AXI_RD_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    input  logic [NUM_REQ*3-1:0]          req_size,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic [1:0]                    rsp_resp,
    output logic                          ar_valid,
    input  logic                          ar_ready,
    output logic [ID_WIDTH-1:0]           ar_id,
    output logic [ADDR_WIDTH-1:0]         ar_addr,
    output logic [7:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    input  logic                          r_valid,
    output logic                          r_ready,
    input  logic [DATA_WIDTH-1:0]         r_data,
    input  logic                          r_last,
    input  logic [1:0]                    r_resp,
    input  logic [ID_WIDTH-1:0]           r_id
);

    localparam int PW = idx_w(NUM_REQ);

    ArbState              state_q;
    ArbState              state_d;
    logic [PW-1:0]        owner_q;
    AxiArReqSt            ar_q;
    logic [NUM_REQ-1:0]   gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic [PW-1:0]        arb_ptr;
    logic                 grant;

    // Single outstanding burst, so r_id carries no routing information.
    logic [AXI_MAX_ADDR_W+ID_WIDTH-1:0] unused_bits;
    assign unused_bits = {ar_q.addr, r_id};

    assign grant = rst_n && (state_q == IDLE) && gnt_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req (req_valid),
        .ptr (arb_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

`ifdef AXI_RD_ARB_RR_EN
    logic [PW-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr;
`else
    assign arb_ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ar_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q   <= gnt_idx;
                ar_q.addr <= AXI_MAX_ADDR_W'(
                    req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]);
                ar_q.len  <= req_len[gnt_idx*8 +: 8];
                ar_q.size <= req_size[gnt_idx*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        ar_valid  = 1'b0;
        ar_id     = '0;
        ar_addr   = '0;
        ar_len    = '0;
        ar_size   = '0;
        ar_burst  = '0;
        r_ready   = 1'b0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        rsp_resp  = '0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready = gnt;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                ar_valid = 1'b1;
                ar_id    = ID_WIDTH'(owner_q);
                ar_addr  = ar_q.addr[ADDR_WIDTH-1:0];
                ar_len   = ar_q.len;
                ar_size  = ar_q.size;
                ar_burst = AXI_BURST_INCR;
                if (ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                rsp_valid[owner_q] = r_valid;
                r_ready            = rsp_ready[owner_q];
                rsp_data           = r_data;
                rsp_last           = r_last;
                rsp_resp           = r_resp;
                if (r_valid && rsp_ready[owner_q] && r_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: grant vector table, burst
// sequences with a beat scoreboard, stalls, AR back-pressure and reset.
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic [N*3-1:0]  req_size;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    logic [1:0]      rsp_resp;
    logic            ar_valid;
    logic            ar_ready;
    logic [IW-1:0]   ar_id;
    logic [AW-1:0]   ar_addr;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;
    logic            r_valid;
    logic            r_ready;
    logic [DW-1:0]   r_data;
    logic            r_last;
    logic [1:0]      r_resp;
    logic [IW-1:0]   r_id;

    axi_rd_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_resp  (rsp_resp),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_id     (ar_id),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_last    (r_last),
        .r_resp    (r_resp),
        .r_id      (r_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    beat_t sb[$];
    int    beats_seen = 0;

    logic [31:0] addr_of [N];
    logic [7:0]  len_of  [N];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 64'(rsp_valid), 64'(oh(e.owner)));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_last", 64'(rsp_last), 64'(e.last));
                chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                chk("r_ready_hs", 64'(r_ready), 64'(1));
                beats_seen++;
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [7:0] l);
        req_addr[i*AW +: AW] = a;
        req_len[i*8 +: 8]    = l;
        req_size[i*3 +: 3]   = 3'b010;
        addr_of[i]           = a;
        len_of[i]            = l;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Entered at posedge+1; returns at posedge+1 of the first ADDR cycle.
    task automatic wait_grant(input int exp_g, output int waited);
        int n;
        int gi;
        n = 0;
        #1;
        while (req_ready == '0 && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("grant", 64'(req_ready), 64'(oh(exp_g)));
        gi = req_ready[1] ? 1 : 0;
        @(posedge clk);
        #1;
        if (n < 30) begin
            req_valid[gi] = 1'b0;
        end
        waited = n;
    endtask

    task automatic serve(input int g, input int ard, input int st_at,
                         input int st_n, input logic [31:0] base,
                         input int kill_at);
        int    start;
        int    len;
        beat_t e;
        start = beats_seen;
        len   = int'(len_of[g]);
        r_valid = 1'b1;
        r_data  = 32'hDEAD;
        r_last  = 1'b1;
        #1;
        chk("ar_valid", 64'(ar_valid), 64'(1));
        chk("ar_addr", 64'(ar_addr), 64'(addr_of[g]));
        chk("ar_len", 64'(ar_len), 64'(len_of[g]));
        chk("ar_id", 64'(ar_id), 64'(g));
        chk("ar_burst", 64'(ar_burst), 64'(2'b01));
        chk("ar_size", 64'(ar_size), 64'(3'b010));
        chk("addr_r_ready", 64'(r_ready), 64'(0));
        chk("addr_rsp_valid", 64'(rsp_valid), 64'(0));
        r_valid = 1'b0;
        r_last  = 1'b0;
        for (int i = 0; i < ard; i++) begin
            tick();
            #1;
            chk("ar_hold_valid", 64'(ar_valid), 64'(1));
            chk("ar_hold_addr", 64'(ar_addr), 64'(addr_of[g]));
            chk("ar_hold_len", 64'(ar_len), 64'(len_of[g]));
            chk("ar_hold_req_ready", 64'(req_ready), 64'(0));
        end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (b == kill_at) begin
                r_valid = 1'b1;
                r_data  = base + 32'(b);
                #1;
                rst_n = 1'b0;
                #1;
                chk("kill_ar_valid", 64'(ar_valid), 64'(0));
                chk("kill_r_ready", 64'(r_ready), 64'(0));
                chk("kill_rsp_valid", 64'(rsp_valid), 64'(0));
                return;
            end
            r_valid = 1'b1;
            r_data  = base + 32'(b);
            r_last  = (b == len);
            r_resp  = (b == 1) ? 2'b10 : 2'b00;
            e.owner = g;
            e.data  = r_data;
            e.last  = r_last;
            e.resp  = r_resp;
            sb.push_back(e);
            if (b == st_at) begin
                rsp_ready[g] = 1'b0;
                for (int s = 0; s < st_n; s++) begin
                    #1;
                    chk("stall_r_ready", 64'(r_ready), 64'(0));
                    chk("stall_rsp_valid", 64'(rsp_valid), 64'(oh(g)));
                    chk("stall_rsp_data", 64'(rsp_data), 64'(r_data));
                    tick();
                end
                rsp_ready[g] = 1'b1;
            end
            #1;
            chk("data_r_ready", 64'(r_ready), 64'(1));
            tick();
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'b00;
        chk("beat_cnt", 64'(beats_seen - start), 64'(len + 1));
    endtask

    typedef struct {
        logic [N-1:0] rv;
        logic         rval;
        logic [N-1:0] exp_rr;
    } vec_t;

    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int exp_g;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_size  = '0;
        rsp_ready = 2'b11;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_data    = '0;
        r_last    = 1'b0;
        r_resp    = '0;
        r_id      = '0;

        vt[0] = '{rv: 2'b00, rval: 1'b0, exp_rr: 2'b00};
        vt[1] = '{rv: 2'b01, rval: 1'b0, exp_rr: 2'b01};
        vt[2] = '{rv: 2'b10, rval: 1'b1, exp_rr: 2'b10};
        vt[3] = '{rv: 2'b11, rval: 1'b1, exp_rr: 2'b01};
        vt[4] = '{rv: 2'b00, rval: 1'b1, exp_rr: 2'b00};

        tick();
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_ar_valid", 64'(ar_valid), 64'(0));
        chk("rst_r_ready", 64'(r_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        req_valid = '0;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            req_valid = vt[i].rv;
            r_valid   = vt[i].rval;
            #1;
            chk("vec_req_ready", 64'(req_ready), 64'(vt[i].exp_rr));
            chk("vec_ar_valid", 64'(ar_valid), 64'(0));
            chk("vec_r_ready", 64'(r_ready), 64'(0));
            chk("vec_rsp_valid", 64'(rsp_valid), 64'(0));
            req_valid = '0;
            r_valid   = 1'b0;
            tick();
        end

        set_req(0, 32'h1C00_0000, 8'd3);
        req_valid = 2'b01;
        wait_grant(0, w);
        serve(0, 2, -1, 0, 32'hA0, -1);
        #1;
        chk("t1_idle_ar_valid", 64'(ar_valid), 64'(0));
        chk("t1_idle_req_ready", 64'(req_ready), 64'(0));
        tick();

        do_reset();
        set_req(0, 32'h8000_1000, 8'd7);
        set_req(1, 32'h8000_2000, 8'd3);
        req_valid = 2'b11;
        wait_grant(0, w);
        serve(0, 5, -1, 0, 32'h100, -1);
        wait_grant(1, w);
        chk("b2b_idle_gap", 64'(w), 64'(0));
        serve(1, 0, 1, 3, 32'h200, -1);
        tick();

        do_reset();
        set_req(0, 32'h0000_4000, 8'd1);
        set_req(1, 32'h0000_5000, 8'd1);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_RD_ARB_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            wait_grant(exp_g, w);
            req_valid = 2'b11;
            serve(exp_g, 0, -1, 0, 32'h300 + 32'(i * 16), -1);
        end
        req_valid = '0;
        tick();

        do_reset();
        set_req(0, 32'h1C00_0100, 8'd3);
        req_valid = 2'b01;
        wait_grant(0, w);
        serve(0, 0, -1, 0, 32'h400, 2);
        sb.delete();
        r_valid = 1'b0;
        r_last  = 1'b0;
        tick();
        chk("kill_hold_rsp_valid", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;
        tick();
        set_req(1, 32'h0000_3000, 8'd1);
        req_valid = 2'b10;
        wait_grant(1, w);
        serve(1, 1, -1, 0, 32'h500, -1);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
